cas_player: RTL and testbench

- FSK tape-playback encoder for the MSX cassette input path.
- Turns a byte stream into the 1200-baud MSX tape waveform that drives the core's cassette audio input, including 2400 Hz header tones, start/stop framing and motor gating.
- Sits between a byte source (SDRAM/ioctl-loaded CAS image reader) and the PSG port A bit 7 input.
- Playback advances only while the core's cassette motor output is asserted.

---
 rtl/cas_player_if.sv | 18 +
 rtl/cas_player.sv | 173 +++++++++++++++++
 tb/tb_cas_player.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cas_player_if.sv
// Byte-source handshake into the MSX cassette playback encoder.
interface cas_player_if;
  logic [7:0] byte_data;
  logic       byte_sync;
  logic       byte_long;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data, byte_sync, byte_long, byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data, byte_sync, byte_long, byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/cas_player.sv
// MSX 1200-baud FSK tape playback encoder (header tone, framing, motor gating).
// Optional leader silence before long headers: define CAS_PLAYER_SILENCE_EN.
module cas_player #(
  parameter int HALF_2400     = 746,
  parameter int LONG_HDR      = 16000,
  parameter int SHORT_HDR     = 4000,
  parameter int SILENCE_TICKS = 3579545
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_3m58,
  input  logic        motor,
  cas_player_if.slave src,
  output logic        cas_audio,
  output logic        busy
);

  localparam int TMAX = (SILENCE_TICKS > 2*HALF_2400) ?
                        SILENCE_TICKS : 2*HALF_2400;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] H1 = TW'(HALF_2400);
  localparam logic [TW-1:0] H2 = TW'(2*HALF_2400);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
`ifdef CAS_PLAYER_SILENCE_EN
    SILENCE = 3'd1,
`endif
    HEADER  = 3'd2,
    START   = 3'd3,
    DATA    = 3'd4,
    STOP    = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick, tick_n, tick_inc;
  logic          half, half_n;
  logic          second, second_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [13:0]   hdr_cnt, hdr_cnt_n;
  logic [13:0]   hdr_tgt, hdr_tgt_n;
  logic [13:0]   hdr_inc;
  logic          audio_n;
  logic          armed;
  logic          go, cur_one, half_end;
  logic [TW-1:0] half_len;

  assign go       = ce_3m58 & motor;
  assign tick_inc = tick + TW'(1);
  assign hdr_inc  = hdr_cnt + 14'd1;
  assign cur_one  = (state == HEADER) | (state == STOP) |
                    ((state == DATA) & shreg[0]);
  assign half_len = cur_one ? H1 : H2;
  assign half_end = go & (tick_inc == half_len);

  assign src.byte_ready = (state == IDLE) & motor & armed;
  assign busy           = (state != IDLE);

  always_comb begin
    state_n   = state;
    tick_n    = tick;
    half_n    = half;
    second_n  = second;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    hdr_cnt_n = hdr_cnt;
    hdr_tgt_n = hdr_tgt;
    audio_n   = cas_audio;
    unique case (state)
      IDLE: begin
        if (src.byte_valid & src.byte_ready) begin
          shreg_n   = src.byte_data;
          hdr_tgt_n = src.byte_long ? 14'(LONG_HDR) : 14'(SHORT_HDR);
          tick_n    = '0;
          half_n    = 1'b0;
          second_n  = 1'b0;
          bit_cnt_n = 3'd0;
          hdr_cnt_n = 14'd0;
          audio_n   = 1'b0;
          state_n   = src.byte_sync ? HEADER : START;
`ifdef CAS_PLAYER_SILENCE_EN
          if (src.byte_sync & src.byte_long) state_n = SILENCE;
`endif
        end
      end
`ifdef CAS_PLAYER_SILENCE_EN
      SILENCE: begin
        if (go) begin
          if (tick_inc == TW'(SILENCE_TICKS)) begin
            tick_n  = '0;
            state_n = HEADER;
          end else begin
            tick_n = tick_inc;
          end
        end
      end
`endif
      default: begin
        if (go & ~half_end) begin
          tick_n = tick_inc;
        end else if (half_end & ~half) begin
          tick_n  = '0;
          half_n  = 1'b1;
          audio_n = 1'b1;
        end else if (half_end) begin
          // End of a pulse: either another pulse follows or the unit ends
          tick_n  = '0;
          half_n  = 1'b0;
          audio_n = 1'b0;
          if (state == HEADER) begin
            if (hdr_inc >= hdr_tgt) begin
              hdr_cnt_n = hdr_tgt;
              state_n   = START;
            end else begin
              hdr_cnt_n = hdr_inc;
            end
          end else if (cur_one & ~second) begin
            second_n = 1'b1;
          end else begin
            second_n = 1'b0;
            if (state == START) begin
              state_n = DATA;
            end else if (state == DATA) begin
              shreg_n = {1'b0, shreg[7:1]};
              if (bit_cnt == 3'd7) begin
                bit_cnt_n = 3'd0;
                state_n   = STOP;
              end else begin
                bit_cnt_n = bit_cnt + 3'd1;
              end
            end else if (bit_cnt == 3'd1) begin
              // Line rests high between frames
              bit_cnt_n = 3'd0;
              audio_n   = 1'b1;
              state_n   = IDLE;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick      <= '0;
      half      <= 1'b0;
      second    <= 1'b0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      hdr_cnt   <= 14'd0;
      hdr_tgt   <= 14'd0;
      cas_audio <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      half      <= half_n;
      second    <= second_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      hdr_cnt   <= hdr_cnt_n;
      hdr_tgt   <= hdr_tgt_n;
      cas_audio <= audio_n;
      armed     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player: waveform, header, motor pause, back-to-back,
// slow clock-enable and reset abort, with per-tick expected levels.
module tb_cas_player;
  localparam int H   = 4;
  localparam int SH  = 2;
  localparam int LH  = 3;
  localparam int SIL = 10;

  logic clk = 1'b0;
  logic reset, ce, motor;
  logic cas_audio, busy;
  int checks = 0;
  int failures = 0;
  bit expq[$];

  cas_player_if bus ();

  cas_player #(
    .HALF_2400(H), .LONG_HDR(LH),
    .SHORT_HDR(SH), .SILENCE_TICKS(SIL)
  ) dut (
    .clk(clk), .reset(reset), .ce_3m58(ce),
    .motor(motor), .src(bus),
    .cas_audio(cas_audio), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void add_pulse(input int h);
    repeat (h) expq.push_back(1'b0);
    repeat (h) expq.push_back(1'b1);
  endfunction

  function automatic void add_bit(input bit b);
    if (b) begin
      add_pulse(H);
      add_pulse(H);
    end else begin
      add_pulse(2*H);
    end
  endfunction

  function automatic void build(input logic [7:0] d,
                                input bit sync, input bit lng);
    expq.delete();
`ifdef CAS_PLAYER_SILENCE_EN
    if (sync && lng) repeat (SIL) expq.push_back(1'b0);
`endif
    if (sync) repeat (lng ? LH : SH) add_pulse(H);
    add_bit(1'b0);
    for (int i = 0; i < 8; i++) add_bit(d[i]);
    add_bit(1'b1);
    add_bit(1'b1);
  endfunction

  // Called at a negedge; returns at the negedge after the frame ends.
  task automatic play(input logic [7:0] d, input bit sync, input bit lng,
                      input int div, input int pause_at, input bit hold,
                      input logic [7:0] nxt, input int abort_at);
    int n;
    int waited;
    build(d, sync, lng);
    n = expq.size();
    waited = 0;
    while (!bus.byte_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_accept", bus.byte_ready, 1);
    bus.byte_data  = d;
    bus.byte_sync  = sync;
    bus.byte_long  = lng;
    bus.byte_valid = 1'b1;
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.byte_valid = 1'b0;
    ce = (div == 1);
    for (int j = 0; j <= n*div; j++) begin
      if (j > 0) @(negedge clk);
      chk("audio", cas_audio, (j < n*div) ? expq[j/div] : 1'b1);
      chk("busy", busy, j < n*div);
      chk("ready", bus.byte_ready, j >= n*div);
      if (j == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("abort_audio", cas_audio, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", bus.byte_ready, 0);
        reset = 1'b0;
        #1;
        chk("abort_ready_after", bus.byte_ready, 0);
        @(negedge clk);
        chk("abort_ready_back", bus.byte_ready, 1);
        chk("abort_audio_idle", cas_audio, 0);
        return;
      end
      if (j == pause_at) begin
        motor = 1'b0;
        repeat (50) begin
          @(negedge clk);
          chk("pause_audio", cas_audio, expq[j/div]);
          chk("pause_busy", busy, 1);
          chk("pause_ready", bus.byte_ready, 0);
        end
        motor = 1'b1;
      end
      if (hold && j == n*div - 1) begin
        bus.byte_data = nxt;
        bus.byte_sync = 1'b0;
        bus.byte_long = 1'b0;
      end
      ce = ((j + 1) % div == 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    ce = 1'b1;
    motor = 1'b1;
    bus.byte_data  = 8'h00;
    bus.byte_sync  = 1'b0;
    bus.byte_long  = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_audio", cas_audio, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.byte_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", bus.byte_ready, 0);
    @(negedge clk);
    chk("ready_up", bus.byte_ready, 1);
    chk("idle_audio", cas_audio, 0);

    play(8'h00, 1'b0, 1'b0, 1, -1, 1'b0, 8'h00, -1);
    play(8'h01, 1'b1, 1'b0, 1, -1, 1'b0, 8'h00, -1);
    play(8'h00, 1'b0, 1'b0, 1, 75, 1'b0, 8'h00, -1);

    play(8'hFF, 1'b0, 1'b0, 1, -1, 1'b1, 8'h00, -1);
    play(8'h00, 1'b0, 1'b0, 1, -1, 1'b0, 8'h00, -1);

    motor = 1'b0;
    bus.byte_data  = 8'h33;
    bus.byte_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("nomotor_ready", bus.byte_ready, 0);
      chk("nomotor_busy", busy, 0);
      chk("nomotor_audio", cas_audio, 1);
    end
    motor = 1'b1;
    play(8'h33, 1'b0, 1'b0, 1, -1, 1'b0, 8'h00, -1);

    play(8'h3C, 1'b1, 1'b1, 1, -1, 1'b0, 8'h00, -1);
    play(8'h5A, 1'b1, 1'b0, 3, -1, 1'b0, 8'h00, -1);
    play(8'h00, 1'b1, 1'b0, 1, -1, 1'b0, 8'h00, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
